// File: rtl/ps2_scan_rx_if.sv
// Key-event bus from the PS/2 receiver to the keyboard controller and display.
// The master drives it and the slave observes it.
interface ps2_scan_rx_if;
  logic [7:0]  code;
  logic        ext;
  logic        brk;
  logic        evt_valid;
  logic [31:0] keycode;
  logic        frame_err;
  logic        busy;

  modport master (output code, ext, brk, evt_valid, keycode, frame_err, busy);
  modport slave  (input  code, ext, brk, evt_valid, keycode, frame_err, busy);
endinterface

// File: rtl/ps2_scan_rx.sv
// PS/2 device-to-host receiver: synchronise, glitch-filter ps2_clk, frame/parity check,
// fold E0/F0 prefixes into key events and keep a 4-byte raw history.
//
// state    | meaning
// ---------+------------------------------------------------
// S_IDLE   | waiting for a start bit (data 0 on a falling edge)
// S_DATA   | shifting in 8 data bits, LSB first
// S_PARITY | latching the parity bit
// S_STOP   | checking stop bit and odd parity, then back to idle
module ps2_scan_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic           CLK,
  input  logic           rst,
  input  logic           ps2_clk,
  input  logic           ps2_data,
  ps2_scan_rx_if.master  evt
);

  localparam int FW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [FW-1:0] F_LAST  = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic          filt_q, filt_d, filt_prev_q;
  logic [FW-1:0] fcnt_q, fcnt_d;
  state_t        state_q, state_d;
  logic [2:0]    bcnt_q, bcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          pend_ext_q, pend_ext_d, pend_brk_q, pend_brk_d;
  logic [7:0]    code_q, code_d;
  logic          ext_q, ext_d, brk_q, brk_d;
  logic          evt_valid_q, evt_valid_d;
  logic [31:0]   keycode_q, keycode_d;
  logic          frame_err_q, frame_err_d;
  logic          busy_q, busy_d;
  logic          strobe, timeout, byte_done;

  // Registered edge detect keeps the strobe at a fixed 2+FILTER_LEN cycles after the raw edge.
  assign strobe  = filt_prev_q & ~filt_q;
  assign timeout = (state_q != S_IDLE) && (tcnt_q == TO_LAST);

  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_s2_q != filt_q) begin
      if (fcnt_q == F_LAST) filt_d = clk_s2_q;
      else                  fcnt_d = fcnt_q + 1'b1;
    end

    if (strobe || state_q == S_IDLE) tcnt_d = '0;
    else                             tcnt_d = tcnt_q + 1'b1;

    state_d     = state_q;
    bcnt_d      = bcnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    pend_ext_d  = pend_ext_q;
    pend_brk_d  = pend_brk_q;
    code_d      = code_q;
    ext_d       = ext_q;
    brk_d       = brk_q;
    keycode_d   = keycode_q;
    evt_valid_d = 1'b0;
    frame_err_d = 1'b0;
    byte_done   = 1'b0;

    if (strobe) begin
      unique case (state_q)
        S_IDLE: if (!dat_s2_q) begin
          state_d = S_DATA;
          bcnt_d  = 3'd0;
        end
        S_DATA: begin
          shift_d = {dat_s2_q, shift_q[7:1]};
          bcnt_d  = bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          par_d   = dat_s2_q;
          state_d = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          if (dat_s2_q && (^shift_q ^ par_q)) byte_done   = 1'b1;
          else                                 frame_err_d = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (timeout) begin
      state_d     = S_IDLE;
      frame_err_d = 1'b1;
    end

    if (byte_done) begin
      keycode_d = {keycode_q[23:0], shift_q};
      if (shift_q == 8'hE0)      pend_ext_d = 1'b1;
      else if (shift_q == 8'hF0) pend_brk_d = 1'b1;
      else begin
        code_d      = shift_q;
        ext_d       = pend_ext_q;
        brk_d       = pend_brk_q;
        evt_valid_d = 1'b1;
        pend_ext_d  = 1'b0;
        pend_brk_d  = 1'b0;
      end
    end
    if (frame_err_d) begin
      pend_ext_d = 1'b0;
      pend_brk_d = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      clk_s1_q    <= 1'b1;
      clk_s2_q    <= 1'b1;
      dat_s1_q    <= 1'b1;
      dat_s2_q    <= 1'b1;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      fcnt_q      <= '0;
      state_q     <= S_IDLE;
      bcnt_q      <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      tcnt_q      <= '0;
      pend_ext_q  <= 1'b0;
      pend_brk_q  <= 1'b0;
      code_q      <= '0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      evt_valid_q <= 1'b0;
      keycode_q   <= '0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      clk_s1_q    <= ps2_clk;
      clk_s2_q    <= clk_s1_q;
      dat_s1_q    <= ps2_data;
      dat_s2_q    <= dat_s1_q;
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      fcnt_q      <= fcnt_d;
      state_q     <= state_d;
      bcnt_q      <= bcnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      tcnt_q      <= tcnt_d;
      pend_ext_q  <= pend_ext_d;
      pend_brk_q  <= pend_brk_d;
      code_q      <= code_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      evt_valid_q <= evt_valid_d;
      keycode_q   <= keycode_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

  assign evt.code      = code_q;
  assign evt.ext       = ext_q;
  assign evt.brk       = brk_q;
  assign evt.evt_valid = evt_valid_q;
  assign evt.keycode   = keycode_q;
  assign evt.frame_err = frame_err_q;
  assign evt.busy      = busy_q;

endmodule

// File: doc/ps2_scan_rx.md
# ps2_scan_rx

PS/2 device-to-host receiver and scan-code decoder that sits directly upstream of the keyboard controller and the scale/tone stage in the piano design. It samples the keyboard's `ps2_clk`/`ps2_data` lines and applies glitch filtering, framing and odd-parity checks. It folds the `E0` (extended) and `F0` (break) prefixes into single key events with a one-cycle valid strobe. It also keeps a 32-bit history of raw received bytes for the seven-segment display.

## Interface
- `FILTER_LEN`, 8: consecutive identical `ps2_clk` samples required to accept a level change (≥2).
- `TIMEOUT_CYC`, 200000: idle `CLK` cycles allowed between falling edges inside a frame (2 ms at 100 MHz).
- `CLK` in 1: system clock; all state is clocked on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `ps2_clk` in 1: raw PS/2 clock from the keyboard. The block only reads it; no host-to-device transfers.
- `ps2_data` in 1: raw PS/2 data from the keyboard.
- `code` out 8: scan code of the last event.
- `ext` out 1: last event carried an `E0` prefix.
- `brk` out 1: last event carried an `F0` prefix (key release).
- `evt_valid` out 1: one-cycle strobe; `code`/`ext`/`brk` are new this cycle.
- `keycode` out 32: raw byte history, newest byte in [7:0].
- `frame_err` out 1: one-cycle strobe on a parity, stop-bit or timeout error.
- `busy` out 1: high while a frame is in progress.

## Operation
- **Synchronisers:** `ps2_clk` and `ps2_data` each pass through a 2-flop synchroniser.
- **Clock filter:**
  - The filtered clock resets to 1.
  - It takes the synchronised level only after `FILTER_LEN` consecutive equal samples.
  - A 1→0 transition of the filtered clock produces a one-cycle `strobe`. The synchronised data is sampled in that cycle.
- **Frame FSM:**
  - IDLE:
    - `strobe` with data 0 (start bit) → DATA, bit count = 0.
    - `strobe` with data 1 → stays in IDLE; no error.
  - DATA: shifts in bits LSB first. After the 8th bit → PARITY.
  - PARITY: latches the parity bit → STOP.
  - STOP:
    - On `strobe`, a good frame requires stop bit = 1 and odd parity (XOR of 8 data bits and parity bit = 1).
    - Good frame → byte_done. Bad frame → `frame_err`.
    - Either way → IDLE.
- **Timeout:**
  - The counter clears on every `strobe` and counts while the FSM is not in IDLE.
  - When it reaches `TIMEOUT_CYC-1` → IDLE, `frame_err` pulses, partial byte discarded.
  - If `strobe` and timeout occur in the same cycle, `strobe` wins.
- **On byte_done:**
  - `keycode` ← {`keycode`[23:0], byte}. Every good byte, including prefixes, enters the history.
  - byte = `E0`: set the pending-ext flag; no event.
  - byte = `F0`: set the pending-brk flag; no event.
  - Any other byte (including `E1`):
    - `code` ← byte, `ext` ← pending-ext, `brk` ← pending-brk, `evt_valid` = 1.
    - Both pending flags then clear.
- Any `frame_err` also clears both pending flags.
- `busy` = (FSM ≠ IDLE).
- **Reset:**
  - All outputs reset to 0: `code`, `ext`, `brk`, `evt_valid`, `keycode`, `frame_err`, `busy`.
  - FSM returns to IDLE, pending flags clear, filtered clock resets to 1, counters reset to 0.
  - A reset in the middle of a frame abandons the frame with no event and no error.

## Timing
- A raw `ps2_clk` falling edge produces `strobe` exactly 2 + `FILTER_LEN` cycles later (constant latency).
- If the stop-bit `strobe` occurs in cycle n:
  - `evt_valid`, `code`, `ext`, `brk` and `keycode` update at the end of cycle n.
  - The new values are visible and `evt_valid` is high in cycle n+1 only.
- `frame_err` is high for exactly the one cycle after the failing `strobe`, or after the timeout.
- `busy` rises the cycle after the start-bit `strobe` and falls the cycle after the stop-bit `strobe`.
- Held state:
  - `code`, `ext` and `brk` hold until the next event.
  - `keycode` holds until the next good byte.
  - Strobes are never back-to-back, because a frame spans ≥ 11·(2+`FILTER_LEN`) cycles.

## Test plan
- **Make code:** send 0x1C (parity 0, stop 1) → one `evt_valid` pulse with `code`=0x1C, `ext`=0, `brk`=0, `keycode`=0x0000001C, `frame_err` never high.
- **Break:** send F0 (parity 1) then 1C → exactly one event with `code`=0x1C, `brk`=1, `ext`=0; `keycode`=0x0000F01C.
- **Extended break:**
  - From reset, send E0, F0, 75 (parity 0, 1, 0) → one event with `code`=0x75, `ext`=1, `brk`=1; `keycode`=0x00E0F075.
  - Then send 0x1C → `ext`=0, `brk`=0.
- **Parity error:**
  - Send 0x1C with parity bit 1 → `frame_err` pulses once, no `evt_valid`, `keycode` unchanged.
  - Sending F0 followed by a bad frame clears pending `brk`; the next good 0x1C reports `brk`=0.
- **Timeout:**
  - Send start bit + 4 data bits, then hold `ps2_clk`=1 → `frame_err` pulses `TIMEOUT_CYC` cycles after the last `strobe`, and `busy` drops.
  - The next complete 0x1C frame decodes correctly.
- **Glitch and reset:**
  - A `ps2_clk` low pulse of `FILTER_LEN`-1 cycles while in IDLE → no `strobe`, `busy` stays 0.
  - Asserting `rst`=0 after 5 bits of a frame → all outputs 0 immediately; after release, a full 0x1C frame gives `keycode`=0x0000001C.
